matrix_write_scheduler: RTL

Sequencer that drains an N×N result matrix from the multiplier's result buffer into the file writer, one element at a time. It walks indices (i, j) in row-major or column-major order, issues a single-cycle-latency read to the result buffer, and presents each value with its coordinates to the writer over a valid/ready handshake. It sits between the result memory and the writer and signals completion once the last element has been accepted.

---
 rtl/matrix_write_scheduler_pkg.sv | 51 +++++
 rtl/matrix_index_walker.sv | 41 ++++
 rtl/matrix_write_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/matrix_write_scheduler_pkg.sv
// Shared definitions for the matrix write scheduler: FSM states and the
// (i, j) index-advance rule used by the index walker.
package matrix_write_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_PUSH,
    ST_DONE
  } state_t;

  // Wide enough for any practical matrix dimension; callers truncate to IDX_W.
  localparam int STEP_W = 16;

  typedef struct packed {
    logic [STEP_W-1:0] next_i;
    logic [STEP_W-1:0] next_j;
    logic              last;
  } index_step_t;

  // Next (i, j) in the chosen traversal order. Both counters wrap explicitly
  // at n-1 so non-power-of-two dimensions walk correctly. 'last' flags the
  // final element (n-1, n-1) of the matrix.
  function automatic index_step_t advance_index(input int unsigned i,
                                                input int unsigned j,
                                                input logic        col_major,
                                                input int unsigned n);
    index_step_t step;
    int unsigned ni;
    int unsigned nj;
    logic        i_end;
    logic        j_end;
    i_end = (i == n - 1);
    j_end = (j == n - 1);
    ni    = i;
    nj    = j;
    if (col_major) begin
      ni = i_end ? 0 : i + 1;
      if (i_end) nj = j_end ? 0 : j + 1;
    end else begin
      nj = j_end ? 0 : j + 1;
      if (j_end) ni = i_end ? 0 : i + 1;
    end
    step.next_i = STEP_W'(ni);
    step.next_j = STEP_W'(nj);
    step.last   = i_end && j_end;
    return step;
  endfunction

endpackage

// File: rtl/matrix_index_walker.sv
// Holds the (i, j) element counters for one matrix drain. 'clear' restarts
// the walk at (0, 0); 'advance' steps to the next element in the latched
// traversal order. 'last' is high while the counters sit on (N-1, N-1).
module matrix_index_walker #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic             col_major,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);
  import matrix_write_scheduler_pkg::*;

  index_step_t step;

  // Compute the successor of the current position and the last-element flag.
  always_comb begin
    step = advance_index(32'(i), 32'(j), col_major, N);
    last = step.last;
  end

  // Counter registers: clear has priority so a new drain always starts at (0, 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
    end else if (clear) begin
      i <= '0;
      j <= '0;
    end else if (advance) begin
      i <= IDX_W'(step.next_i);
      j <= IDX_W'(step.next_j);
    end
  end

endmodule

// File: rtl/matrix_write_scheduler.sv
// Drains an N x N result matrix from the result buffer to the file writer,
// one element per FETCH/CAPTURE/PUSH round, with a valid/ready handshake on
// the writer side and a one-cycle done pulse after the final element.
module matrix_write_scheduler #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              col_major,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_row,
  output logic [IDX_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_valid,
  output logic [DATA_W-1:0] wr_value,
  output logic [IDX_W-1:0]  wr_i,
  output logic [IDX_W-1:0]  wr_j,
  input  logic              wr_ready
);
  import matrix_write_scheduler_pkg::*;

  state_t           state;
  logic             col_major_q;
  logic [IDX_W-1:0] cur_i;
  logic [IDX_W-1:0] cur_j;
  logic             last;
  logic             walk_clear;
  logic             walk_advance;

  // The walker restarts on an accepted start and steps after each non-final
  // handshake, so it already holds the next address when FETCH is entered.
  assign walk_clear   = (state == ST_IDLE) && start;
  assign walk_advance = (state == ST_PUSH) && wr_ready && !last;

  // The read address is taken straight from the walker's counter registers.
  assign rd_row = cur_i;
  assign rd_col = cur_j;

  matrix_index_walker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (walk_clear),
    .advance   (walk_advance),
    .col_major (col_major_q),
    .i         (cur_i),
    .j         (cur_j),
    .last      (last)
  );

  // Drain FSM; every control and data output is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      wr_valid    <= 1'b0;
      wr_value    <= '0;
      wr_i        <= '0;
      wr_j        <= '0;
      col_major_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_FETCH;
            busy        <= 1'b1;
            rd_en       <= 1'b1;
            col_major_q <= col_major;
          end
        end
        ST_FETCH: begin
          rd_en <= 1'b0;
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          wr_value <= rd_data;
          wr_i     <= cur_i;
          wr_j     <= cur_j;
          wr_valid <= 1'b1;
          state    <= ST_PUSH;
        end
        ST_PUSH: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (last) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
              rd_en <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
